// File: rtl/reg_bus_xchg_if.sv
// Handshake and bus signals of reg_bus_xchg.
// The master side issues requests; the slave side is the transfer controller.
interface reg_bus_xchg_if #(
    parameter int NREGS = 4,
    parameter int WIDTH = 8,
    localparam int IW = $clog2(NREGS)
);
    logic                   start;
    logic [1:0]             op;
    logic [IW-1:0]          sel_a;
    logic [IW-1:0]          sel_b;
    logic [WIDTH-1:0]       din;
    logic                   busy;
    logic                   done;
    logic [2:0]             state;
    logic [WIDTH-1:0]       bus;
    logic [NREGS*WIDTH-1:0] regs_flat;

    modport master (
        output start, op, sel_a, sel_b, din,
        input  busy, done, state, bus, regs_flat
    );

    modport slave (
        input  start, op, sel_a, sel_b, din,
        output busy, done, state, bus, regs_flat
    );
endinterface

// File: rtl/reg_bus_xchg.sv
// Register bank with a single internal bus; sequences swap, rotate-up and load
// transfers, one register-to-register move per clock.
//
// state | meaning
// IDLE  | waiting for start, captures op/sel/din
// SW1   | swap: tmp <= r[a]
// SW2   | swap: r[a] <= r[b]
// SW3   | swap: r[b] <= tmp
// ROT   | rotate: tmp <= r[N-1], then r[k] <= r[k-1] down to k=1, then r[0] <= tmp
// LOAD  | r[a] <= din
// DONE  | one-cycle completion pulse
module reg_bus_xchg #(
    parameter int NREGS = 4,
    parameter int WIDTH = 8
) (
    input logic         clk,
    input logic         rst,
    reg_bus_xchg_if.slave bif
);
    localparam int IW = $clog2(NREGS);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SW1  = 3'd1,
        SW2  = 3'd2,
        SW3  = 3'd3,
        ROT  = 3'd4,
        LOAD = 3'd5,
        DONE = 3'd6
    } state_t;

    state_t           st, st_nxt;
    logic [WIDTH-1:0] r [NREGS];
    logic [WIDTH-1:0] tmp;
    logic [IW-1:0]    a_q, b_q;
    logic [WIDTH-1:0] din_q;
    logic [IW-1:0]    k, k_nxt;
    logic             rot_first, rot_first_nxt;

    logic [WIDTH-1:0] bus_v;
    logic             bank_we, tmp_we;
    logic [IW-1:0]    bank_idx;
    logic             a_bad, b_bad;

    always_ff @(posedge clk) begin
        if (!rst) begin
            st        <= IDLE;
            tmp       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            din_q     <= '0;
            k         <= '0;
            rot_first <= 1'b0;
            for (int i = 0; i < NREGS; i++) r[i] <= WIDTH'(i + 1);
        end else begin
            st        <= st_nxt;
            k         <= k_nxt;
            rot_first <= rot_first_nxt;
            if (st == IDLE && bif.start) begin
                a_q   <= bif.sel_a;
                b_q   <= bif.sel_b;
                din_q <= bif.din;
            end
            if (tmp_we)  tmp         <= bus_v;
            if (bank_we) r[bank_idx] <= bus_v;
        end
    end

    always_comb begin
        st_nxt        = st;
        k_nxt         = k;
        rot_first_nxt = rot_first;
        bus_v         = '0;
        bank_we       = 1'b0;
        tmp_we        = 1'b0;
        bank_idx      = a_q;
        a_bad         = int'(bif.sel_a) >= NREGS;
        b_bad         = int'(bif.sel_b) >= NREGS;
        case (st)
            IDLE: begin
                k_nxt         = IW'(NREGS - 1);
                rot_first_nxt = 1'b1;
                if (bif.start) begin
                    case (bif.op)
                        2'b00:   st_nxt = (a_bad || b_bad) ? DONE : SW1;
                        2'b01:   st_nxt = ROT;
                        2'b10:   st_nxt = a_bad ? DONE : LOAD;
                        default: st_nxt = DONE;
                    endcase
                end
            end
            SW1: begin
                bus_v  = r[a_q];
                tmp_we = 1'b1;
                st_nxt = SW2;
            end
            SW2: begin
                bus_v    = r[b_q];
                bank_we  = 1'b1;
                bank_idx = a_q;
                st_nxt   = SW3;
            end
            SW3: begin
                bus_v    = tmp;
                bank_we  = 1'b1;
                bank_idx = b_q;
                st_nxt   = DONE;
            end
            ROT: begin
                // first cycle parks the top register; k only starts counting after it
                if (rot_first) begin
                    bus_v         = r[NREGS-1];
                    tmp_we        = 1'b1;
                    rot_first_nxt = 1'b0;
                end else if (k == '0) begin
                    bus_v    = tmp;
                    bank_we  = 1'b1;
                    bank_idx = '0;
                    st_nxt   = DONE;
                end else begin
                    bus_v    = r[k - IW'(1)];
                    bank_we  = 1'b1;
                    bank_idx = k;
                    k_nxt    = k - IW'(1);
                end
            end
            LOAD: begin
                bus_v    = din_q;
                bank_we  = 1'b1;
                bank_idx = a_q;
                st_nxt   = DONE;
            end
            DONE:    st_nxt = IDLE;
            default: st_nxt = IDLE;
        endcase
    end

    always_comb begin
        bif.regs_flat = '0;
        for (int i = 0; i < NREGS; i++) bif.regs_flat[i*WIDTH +: WIDTH] = r[i];
    end

    assign bif.bus   = bus_v;
    assign bif.busy  = (st != IDLE);
    assign bif.done  = (st == DONE);
    assign bif.state = st;
endmodule

// File: doc/reg_bus_xchg.md
Name: reg_bus_xchg

Overview:
- Parametrised bus-transfer controller over a bank of NREGS registers, WIDTH bits each, sharing one internal bus.
- Performs at most one register-to-register transfer per clock.
- Supports three operations, started by a start/busy/done handshake:
  - swap of two selected registers through a dedicated temp register;
  - full-bank rotate;
  - direct load.
- Next-generation successor of the fixed 3-register swap FSM. Sits beside the datapath as a self-contained register file with sequenced transfers.

Parameters:
- NREGS, 4, number of bank registers (>=2).
- WIDTH, 8, bits per register.
- IW, $clog2(NREGS), index width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock, the only clock.
- rst  input  1  synchronous reset, active-low (sampled on posedge clk; 0 = reset).
- start  input  1  request; sampled only in IDLE.
- op  input  2  00 swap, 01 rotate, 10 load, 11 reserved.
- sel_a  input  IW  first index (swap/load target).
- sel_b  input  IW  second index (swap only).
- din  input  WIDTH  load data.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- state  output  3  current FSM state code.
- bus  output  WIDTH  value transferred this cycle; 0 when no transfer.
- regs_flat  output  NREGS*WIDTH  bank contents; r[i] at bits [i*WIDTH +: WIDTH].

Behaviour:
- Reset (rst=0 at posedge):
  - r[i] <= i+1; tmp <= 0.
  - State goes to IDLE; busy=0, done=0, bus=0.
  - Internal op/sel/din captures cleared.
  - Reset overrides everything, including mid-operation: the operation is aborted and any partial transfer is discarded.
- States and codes: IDLE=0, SW1=1, SW2=2, SW3=3, ROT=4, LOAD=5, DONE=6.
- IDLE:
  - start=1 captures op, sel_a, sel_b, din into internal registers.
  - Next state: 00->SW1, 01->ROT (counter k <= NREGS-1), 10->LOAD, 11->DONE.
  - If any used index >= NREGS, go to DONE with no change.
  - start=0: stay in IDLE.
- While busy, start, op, sel_a, sel_b and din are ignored. Only the captured values are used.
- Swap:
  - SW1: tmp <= r[a].
  - SW2: r[a] <= r[b].
  - SW3: r[b] <= tmp.
  - Each state moves to the next; SW3 -> DONE.
  - a==b is legal: 3 transfers, contents unchanged.
- Rotate (up):
  - ROT, k=NREGS-1 first cycle: tmp <= r[NREGS-1].
  - Then, for k = NREGS-1 down to 1: r[k] <= r[k-1], and k decrements.
  - Final ROT cycle: r[0] <= tmp, then -> DONE.
  - Total NREGS+1 transfer cycles.
  - Result: new r[i] = old r[i-1], new r[0] = old r[NREGS-1].
- LOAD: r[a] <= din, then -> DONE.
- DONE: done=1 for exactly this cycle, busy=1, then -> IDLE. A start can be accepted in the following IDLE cycle.
- Latency, counted from the edge that samples start: swap done after 4 cycles, rotate after NREGS+2, load after 2, reserved/invalid after 1.
- bus:
  - Combinationally equals the source value of the transfer made in the current state: r[a] in SW1, r[b] in SW2, tmp in SW3, etc.
  - Equals din in LOAD; 0 in IDLE and DONE.
- No arithmetic is performed; all transfers are full WIDTH and unsigned.

Test Plan (NREGS=4, WIDTH=8):
- Reset: hold rst=0 for 2 cycles -> regs_flat=32'h04030201, tmp=0, busy=0, done=0, state=0.
- Swap: start, op=00, sel_a=0, sel_b=2 -> bus shows 01, 03, 01 on successive cycles; done pulses 4 cycles after start; r0=03, r2=01.
- Rotate: from reset state, op=01 -> 5 transfer cycles; done pulses after 6 cycles; regs_flat=32'h03020104.
- Load, then a==b swap: load sel_a=3 din=8'hA5 -> r3=A5, done after 2 cycles; then swap sel_a=sel_b=3 -> r3 still A5, 3 transfer cycles.
- Reserved op and ignored start: op=11 -> done after 1 cycle, regs unchanged. Toggle start/sel during a swap -> original swap result only, no second operation.
- Reset mid-op: assert rst=0 in the SW2 cycle of a swap -> next cycle regs=04030201, state=IDLE, done never pulses.
